// File: rtl/wb_sequencer.sv
// wb_sequencer: holds off register write-back until its source is valid, then issues one RegWrite
module wb_sequencer #(
  parameter int WAIT_MAX = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_req,
  input  logic [3:0]       wb_src,
  input  logic [4:0]       wb_dst,
  input  logic             hilo_busy,
  input  logic             load_ready,
  output logic [3:0]       MemToReg,
  output logic             RegWrite,
  output logic [4:0]       WriteReg,
  output logic             wb_busy,
  output logic             wb_done,
  output logic             wb_err,
  output logic [CNT_W-1:0] wb_count
);
  typedef enum logic [1:0] {IDLE, WAIT, WRITE, ERR} state_t;
  state_t state_q, state_d;
  logic [3:0] src_q, src_d, mem_q, mem_d;
  logic [4:0] dst_q, dst_d, wr_q, wr_d;
  logic [7:0] wait_q, wait_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic rw_q, rw_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic need_wait, ready;
  assign need_wait = (wb_src == 4'd1 && !load_ready) || ((wb_src == 4'd3 || wb_src == 4'd4) && hilo_busy);
  assign ready = (src_q == 4'd1) ? load_ready : !hilo_busy;
  always_comb begin
    state_d = state_q;
    src_d = src_q;
    dst_d = dst_q;
    wait_d = wait_q;
    case (state_q)
      IDLE: if (wb_req) begin
        src_d = wb_src;
        dst_d = wb_dst;
        wait_d = 8'd0;
        state_d = (wb_src > 4'd10) ? ERR : need_wait ? WAIT : WRITE;
      end
      WAIT: begin
        wait_d = wait_q + 8'd1;
        state_d = ready ? WRITE : (wait_q == 8'(WAIT_MAX - 1)) ? ERR : WAIT;
      end
      default: state_d = IDLE;
    endcase
    // outputs are registered from the next state so they line up with it
    mem_d = (state_d == WAIT || state_d == WRITE) ? src_d : 4'd0;
    rw_d = state_d == WRITE && dst_d != 5'd0;
    wr_d = (state_d == WRITE) ? dst_d : 5'd0;
    busy_d = state_d != IDLE;
    done_d = state_d == WRITE;
    err_d = state_d == ERR;
    count_d = count_q + CNT_W'(rw_q);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q <= '0;
      dst_q <= '0;
      wait_q <= '0;
      count_q <= '0;
      mem_q <= '0;
      rw_q <= 1'b0;
      wr_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      dst_q <= dst_d;
      wait_q <= wait_d;
      count_q <= count_d;
      mem_q <= mem_d;
      rw_q <= rw_d;
      wr_q <= wr_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign MemToReg = mem_q;
  assign RegWrite = rw_q;
  assign WriteReg = wr_q;
  assign wb_busy = busy_q;
  assign wb_done = done_q;
  assign wb_err = err_q;
  assign wb_count = count_q;
endmodule

// File: tb/tb_wb_sequencer.sv
// tb_wb_sequencer: directed checks of wb_sequencer; a WAIT_MAX=4 twin shares the inputs for the timeout case
module tb_wb_sequencer;
  logic clk = 1'b0, reset = 1'b1, wb_req = 1'b0, hilo_busy = 1'b0, load_ready = 1'b1;
  logic [3:0] wb_src = '0;
  logic [4:0] wb_dst = '0;
  logic [3:0] m2r, m2r4;
  logic rw, busy, done, err, rw4, busy4, done4, err4;
  logic [4:0] wr, wr4;
  logic [3:0] cnt;
  logic [15:0] cnt4;
  int n_cmp = 0, n_err = 0;
  logic [3:0] exp_cnt;
  always #5 clk = ~clk;
  wb_sequencer #(.WAIT_MAX(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .wb_req(wb_req), .wb_src(wb_src), .wb_dst(wb_dst),
    .hilo_busy(hilo_busy), .load_ready(load_ready), .MemToReg(m2r), .RegWrite(rw),
    .WriteReg(wr), .wb_busy(busy), .wb_done(done), .wb_err(err), .wb_count(cnt));
  wb_sequencer #(.WAIT_MAX(4), .CNT_W(16)) dut4 (
    .clk(clk), .reset(reset), .wb_req(wb_req), .wb_src(wb_src), .wb_dst(wb_dst),
    .hilo_busy(hilo_busy), .load_ready(load_ready), .MemToReg(m2r4), .RegWrite(rw4),
    .WriteReg(wr4), .wb_busy(busy4), .wb_done(done4), .wb_err(err4), .wb_count(cnt4));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic req(input logic [3:0] s, input logic [4:0] d);
    wb_req = 1'b1;
    wb_src = s;
    wb_dst = d;
  endtask
  initial begin
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_rw", rw, 0);
    chk("rst_m2r", m2r, 0);
    chk("rst_cnt", cnt, 0);
    req(4'd0, 5'd8);
    tick();
    wb_req = 1'b0;
    chk("w0_m2r", m2r, 0);
    chk("w0_wr", wr, 8);
    chk("w0_rw", rw, 1);
    chk("w0_done", done, 1);
    chk("w0_busy", busy, 1);
    tick();
    chk("w0_rw_off", rw, 0);
    chk("w0_done_off", done, 0);
    chk("w0_idle", busy, 0);
    chk("w0_cnt", cnt, 1);
    req(4'd3, 5'd9);
    hilo_busy = 1'b1;
    tick();
    wb_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("hilo_busy", busy, 1);
      chk("hilo_m2r", m2r, 3);
      chk("hilo_rw", rw, 0);
      if (i == 5) hilo_busy = 1'b0;
      tick();
    end
    chk("hilo_wr_rw", rw, 1);
    chk("hilo_wr_dst", wr, 9);
    chk("hilo_wr_m2r", m2r, 3);
    tick();
    chk("hilo_once", rw, 0);
    chk("hilo_cnt", cnt, 2);
    req(4'd1, 5'd3);
    load_ready = 1'b0;
    tick();
    wb_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("to_busy", busy, 1);
      chk("to_err", err, 0);
      chk("to_m2r", m2r, 1);
      if (i < 4) chk("to4_wait", {busy4, err4}, 2'b10);
      if (i == 4) chk("to4_err", {busy4, err4, rw4, m2r4}, 7'b1100000);
      tick();
    end
    chk("to_errpulse", err, 1);
    chk("to_err_rw", rw, 0);
    chk("to_err_m2r", m2r, 0);
    load_ready = 1'b1;
    tick();
    chk("to_idle", {busy, err}, 2'b00);
    chk("to_cnt", cnt, 2);
    req(4'd12, 5'd5);
    tick();
    wb_req = 1'b0;
    chk("ill_err", err, 1);
    chk("ill_done", {done, rw}, 2'b00);
    tick();
    chk("ill_idle", {busy, err}, 2'b00);
    req(4'd5, 5'd0);
    tick();
    wb_req = 1'b0;
    chk("d0_done", done, 1);
    chk("d0_rw", rw, 0);
    chk("d0_m2r", m2r, 5);
    tick();
    chk("d0_cnt", cnt, 2);
    req(4'd4, 5'd7);
    hilo_busy = 1'b1;
    tick();
    wb_req = 1'b0;
    chk("rw_wait_m2r", m2r, 4);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rw_rst_outs", {busy, rw, done, err, m2r, wr}, 0);
    chk("rw_rst_cnt", cnt, 0);
    hilo_busy = 1'b0;
    tick();
    chk("rw_nowrite1", {rw, done, busy}, 0);
    tick();
    chk("rw_nowrite2", {rw, done, busy}, 0);
    req(4'd0, 5'd2);
    tick();
    chk("b2b_w1", rw, 1);
    req(4'd9, 5'd4);
    tick();
    chk("b2b_ignored", {busy, rw}, 2'b00);
    tick();
    chk("b2b_w2", {rw, wr, m2r}, {1'b1, 5'd4, 4'd9});
    req(4'd0, 5'd1);
    exp_cnt = 4'd1;
    for (int i = 0; i < 14; i++) begin
      tick();
      exp_cnt = exp_cnt + 4'd1;
      chk("b2b_idle", rw, 0);
      chk("b2b_cnt", cnt, 32'(exp_cnt));
      tick();
      chk("b2b_wr", rw, 1);
    end
    wb_req = 1'b0;
    tick();
    chk("wrap_cnt", cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/wb_sequencer.md
# wb_sequencer

Write-back sequencer for the multicycle datapath. It accepts one write-back request at a time from the main control unit and drives the 4-bit `MemToReg` select of the register-file write-data mux. It holds off the write while the selected source is not yet valid: HI/LO while the mult/div unit is busy, or load data before the load/store control reports ready. It then issues a single-cycle `RegWrite` with the latched destination register.

## Interface
Parameters:
- `WAIT_MAX`, default 64: maximum cycles spent in WAIT before abort; legal range 2..255.
- `CNT_W`, default 16: width of the completed-write counter.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wb_req`  in  1  request strobe; sampled only in IDLE.
- `wb_src`  in  4  write-data source code, sampled with `wb_req`:
  - 0 ALUOut, 1 load data, 2 imm<<16, 3 HI, 4 LO, 5 constant 227;
  - 6 sign-extended imm, 7 shifter, 8 B, 9 A, 10 LT result;
  - 11..15 illegal.
- `wb_dst`  in  5  destination register number, sampled with `wb_req`.
- `hilo_busy`  in  1  mult/div unit still computing HI/LO.
- `load_ready`  in  1  load data on the load/store control output is valid.
- `MemToReg`  out  4  mux select.
- `RegWrite`  out  1  register-bank write enable.
- `WriteReg`  out  5  register-bank write address.
- `wb_busy`  out  1  high in every state except IDLE.
- `wb_done`  out  1  one-cycle pulse: request completed (written or suppressed).
- `wb_err`  out  1  one-cycle pulse: illegal source or wait timeout.
- `wb_count`  out  `CNT_W`  number of `RegWrite` pulses issued; wraps modulo 2^`CNT_W`.

## Operation
- States are IDLE, WAIT, WRITE and ERR. The encoding is free; all outputs are registered.
- **IDLE**
  - Outputs: `MemToReg`=0, `RegWrite`=0, `WriteReg`=0.
  - On `wb_req`=1, latch `wb_src`/`wb_dst` and branch:
    - src>10 → ERR;
    - src∈{3,4} and `hilo_busy`=1 → WAIT;
    - src=1 and `load_ready`=0 → WAIT;
    - otherwise → WRITE.
- **WAIT**
  - `MemToReg` shows the latched src.
  - `wait_cnt` is cleared on entry and increments each WAIT cycle.
  - Each cycle, evaluate readiness: for src 3/4, `hilo_busy`=0; for src 1, `load_ready`=1.
  - If ready → WRITE. Else if `wait_cnt`=`WAIT_MAX`-1 → ERR. Ready has priority over timeout in the same cycle.
- **WRITE**
  - Outputs: `MemToReg`=latched src, `WriteReg`=latched dst, `wb_done`=1.
  - `RegWrite`=1 only if latched dst≠0; dst=0 suppresses the write but still completes, and `wb_count` does not increment.
  - Next state is IDLE.
- **ERR**
  - Outputs: `wb_err`=1, `RegWrite`=0, `wb_done`=0, `MemToReg`=0.
  - Next state is IDLE.
- `wb_req` while `wb_busy`=1 is ignored; it is not queued.
- `wb_count` increments in each cycle that `RegWrite`=1.
- **Reset (any state, including mid-WAIT or WRITE)**: next cycle IDLE; all outputs 0, `wb_count`=0, `wait_cnt`=0. No `RegWrite` is issued for the aborted request.

## Timing
- Request sampled at edge N with no wait needed: WRITE during cycle N+1, with `RegWrite`/`wb_done` high for exactly that cycle; IDLE at N+2. The next request is accepted at edge N+2.
- Source becomes ready during wait cycle k (k=0 is the first WAIT cycle): WRITE at cycle k+1 of WAIT-relative time. Total latency from the sampling edge is k+2 cycles.
- Timeout: at most `WAIT_MAX` cycles in WAIT, then one ERR cycle. Request-to-`wb_err` latency is `WAIT_MAX`+1 cycles.
- `MemToReg` is stable from the cycle after sampling through the WRITE cycle, so the mux output has settled before the `RegWrite` edge.
- Back-to-back throughput is one write per 2 cycles minimum.

## Test plan
- Reset, then `wb_req`=1 with src=0, dst=8 → next cycle `MemToReg`=0, `WriteReg`=8, `RegWrite`=1, `wb_done`=1 for one cycle; `wb_count`=1.
- src=3, dst=9 with `hilo_busy` high for 5 cycles after the request → `wb_busy`=1 and `MemToReg`=3 throughout WAIT; `RegWrite` pulses exactly once, on the cycle after `hilo_busy` falls.
- src=1, `load_ready` held 0, `WAIT_MAX`=4 → 4 WAIT cycles, then `wb_err` pulse; no `RegWrite`; `wb_count` unchanged.
- src=12 → `wb_err` pulse the next cycle, IDLE after; src=5, dst=0 → `wb_done`=1, `RegWrite`=0, `MemToReg`=5.
- Assert `reset` during WAIT (src=4, `hilo_busy`=1) → IDLE the next cycle, all outputs 0; a later `hilo_busy` fall produces no write.
- Second `wb_req` asserted during WRITE → ignored; `wb_req` held continuously → one write every 2 cycles; `wb_count` wraps from 0xFFFF to 0.
